filter_bank: RTL
================

// Module: filter_bank
// PURPOSE
//  Parametrised multi-channel moving-sum filter bank with per-channel peak detection.
//  Next-generation filter stage: one ADC stream from exp_sig_gen drives NUM_CH channels,
//  each with a runtime-selectable window (power of two), sharing a single delay line.
//  Outputs feed the same bench/monitoring path as the per-variant filter outputs.
// PARAMETERS
//  NUM_CH        4                    number of filter channels
//  DATA_W        SIZE_ADC_DATA        input sample width (unsigned)
//  MAX_LOG2_WIN  5                    log2 of maximum window; delay line depth 2**MAX_LOG2_WIN
//  OUT_W         DATA_W+MAX_LOG2_WIN  sum/peak width; no overflow possible
// PORTS
//  clk          in   1                    clock
//  reset        in   1                    asynchronous, active-low reset
//  in_valid     in   1                    sample strobe
//  in_data      in   DATA_W               ADC sample
//  cfg_load     in   1                    1-cycle pulse; latch cfg_log2_win, restart filters
//  cfg_log2_win in   NUM_CH*3             per-channel log2 window, 0..MAX_LOG2_WIN; larger values clamp to max
//  cfg_thr      in   OUT_W                peak threshold, common to all channels; sampled each cycle
//  out_valid    out  1                    filtered sample strobe
//  out_data     out  NUM_CH*OUT_W         per-channel moving sums; ch0 in LSBs
//  peak_valid   out  NUM_CH               1-cycle pulse per channel at end of peak
//  peak_data    out  NUM_CH*OUT_W         peak maximum; held until the next peak
// BEHAVIOUR
//  Reset:
//   - all outputs 0
//   - delay line, sums and window registers 0 (window 1)
//   - peak FSMs in IDLE
//  Delay line:
//   - 2**MAX_LOG2_WIN registers and a wr_ptr.
//   - On in_valid, in_data is written at wr_ptr and wr_ptr increments, wrapping modulo depth.
//  Channel c with W = 2**log2_win[c]:
//   - On in_valid: sum <= sum + in_data - line[(wr_ptr - W) mod depth], using the old line contents.
//   - Latency: out_valid and out_data are registered one cycle after in_valid. out_valid stays low otherwise.
//  Fill:
//   - Line entries start at 0, so the first W-1 outputs are the partial sums of the samples seen so far.
//   - W = 2**MAX_LOG2_WIN reads the slot being overwritten (the oldest sample). This is correct.
//  cfg_load:
//   - Latches new windows and clears the delay line, all sums, wr_ptr and the peak FSMs.
//   - Any pending peak is dropped without a peak_valid pulse.
//   - If in_valid occurs in the same cycle, the clear wins and that sample is then processed as
//     the first sample after the clear (out_valid asserted next cycle with sum = in_data).
//  Peak FSM per channel, evaluated on each new sum (the cycle out_valid rises):
//   - IDLE -> ABOVE when sum > cfg_thr; max <= sum.
//   - ABOVE: if sum > cfg_thr, max <= max(max, sum).
//   - ABOVE: otherwise peak_data <= max, peak_valid pulses 1 cycle, back to IDLE.
//   - Equality with the threshold counts as below.
//   - Peak latency: peak_valid in the same cycle as the first out_valid at or below threshold.
//  Reset deasserting mid-stream: the block restarts as after cfg_load; there is no partial state.
// CONFIGURATION
//  FILTER_BANK_PEAK_EN defined:
//   - Peak FSMs, max registers and the peak outputs are built as above.
//  FILTER_BANK_PEAK_EN undefined:
//   - peak_valid tied to 0 and peak_data tied to 0; cfg_thr ignored.
//   - Filter path identical, cycle for cycle.
// STRUCTURE
//  package_settings holds:
//   - SIZE_ADC_DATA
//   - FB_MAX_LOG2_WIN constant
//   - typedef enum logic {PK_IDLE, PK_ABOVE} pk_state_t
//  Sub-module filter_bank_channel:
//   - one window register, sum, and peak FSM
//   - takes in_data, the tapped old sample, valid and threshold
//   - instantiated NUM_CH times via generate
//  Top level owns the delay line, wr_ptr, cfg latching and the output registers.
// TESTING (NUM_CH=4, DATA_W=12, MAX_LOG2_WIN=5)
//  1 Reset: hold reset=0 with in_valid toggling -> all outputs 0. Release; first sample 5 at win=1 -> out 5 one cycle later.
//  2 Step: cfg_log2_win ch0=2, cfg_load; then in_data=100 each valid ->
//    ch0 sums 100,200,300,400,400...; ch with log2=5 reaches 3200 after 32 samples.
//  3 Wrap: 100 samples with ramp 0..99, win=8 -> each output equals the sum of the last 8
//    samples, e.g. sample 99 -> 764. Sparse in_valid (1 in 3) gives identical values.
//  4 Peak (PEAK_EN): thr=250, win=1, samples 100,300,500,400,200 ->
//    peak_valid once, aligned with the output of 200, peak_data=500. No pulse for an equal-to-threshold sample.
//  5 cfg_load mid-peak together with in_valid=7 -> no peak_valid; next out_data=7; ch windows updated.
//  6 Build without FILTER_BANK_PEAK_EN, rerun 2 and 4 -> identical out_data; peak_valid and peak_data stay 0.

Source files
------------

// File: rtl/package_settings.sv
// Shared settings for the filter bank: ADC sample width, maximum window
// exponent, peak FSM state encoding and the window-exponent clamp helper.
package package_settings;

    localparam int unsigned SIZE_ADC_DATA   = 12;
    localparam int unsigned FB_MAX_LOG2_WIN = 5;

    typedef enum logic {PK_IDLE, PK_ABOVE} pk_state_t;

    // Out-of-range window exponents saturate at the largest supported window.
    function automatic logic [2:0] clamp_log2(input logic [2:0] v, input int unsigned max_log2);
        return (32'(v) > max_log2) ? 3'(max_log2) : v;
    endfunction

endpackage

// File: rtl/filter_bank_channel.sv
// One filter channel: window register, running moving sum and, when
// FILTER_BANK_PEAK_EN is defined, the peak FSM with its max register.
module filter_bank_channel
    import package_settings::*;
#(
    parameter int unsigned DATA_W       = SIZE_ADC_DATA,
    parameter int unsigned MAX_LOG2_WIN = FB_MAX_LOG2_WIN,
    parameter int unsigned OUT_W        = DATA_W + MAX_LOG2_WIN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              valid,
    input  logic [2:0]        cfg_log2_win,
    input  logic [DATA_W-1:0] in_data,
    input  logic [DATA_W-1:0] old_data,
    input  logic [OUT_W-1:0]  thr,
    output logic [2:0]        log2_win,
    output logic [OUT_W-1:0]  sum,
    output logic              peak_valid,
    output logic [OUT_W-1:0]  peak_data
);

    logic [OUT_W-1:0] sum_next;

    // Next sum; a clear restarts from an empty window, so the tapped sample is ignored.
    always_comb begin
        sum_next = clear ? '0 : sum;
        sum_next = sum_next + OUT_W'(in_data);
        if (!clear) begin
            sum_next = sum_next - OUT_W'(old_data);
        end
    end

    // Window register and running sum.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            log2_win <= '0;
            sum      <= '0;
        end else begin
            if (clear) begin
                log2_win <= clamp_log2(cfg_log2_win, MAX_LOG2_WIN);
            end
            if (valid) begin
                sum <= sum_next;
            end else if (clear) begin
                sum <= '0;
            end
        end
    end

`ifdef FILTER_BANK_PEAK_EN
    pk_state_t        state, state_next, state_cur;
    logic [OUT_W-1:0] max_q, max_next;
    logic             pv_next;
    logic [OUT_W-1:0] pd_next;

    // Peak decision is made on sum_next so the pulse lines up with out_valid.
    // A clear drops any pending peak and evaluates the new sample from IDLE.
    always_comb begin
        state_cur  = clear ? PK_IDLE : state;
        state_next = state_cur;
        max_next   = clear ? '0 : max_q;
        pv_next    = 1'b0;
        pd_next    = peak_data;
        if (valid) begin
            case (state_cur)
                PK_IDLE: begin
                    if (sum_next > thr) begin
                        state_next = PK_ABOVE;
                        max_next   = sum_next;
                    end
                end
                PK_ABOVE: begin
                    if (sum_next > thr) begin
                        if (sum_next > max_q) begin
                            max_next = sum_next;
                        end
                    end else begin
                        state_next = PK_IDLE;
                        pv_next    = 1'b1;
                        pd_next    = max_q;
                    end
                end
                default: state_next = PK_IDLE;
            endcase
        end
    end

    // Peak FSM state, max and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= PK_IDLE;
            max_q      <= '0;
            peak_valid <= 1'b0;
            peak_data  <= '0;
        end else begin
            state      <= state_next;
            max_q      <= max_next;
            peak_valid <= pv_next;
            peak_data  <= pd_next;
        end
    end
`else
    logic unused_thr;

    assign unused_thr = ^thr;
    assign peak_valid = 1'b0;
    assign peak_data  = '0;
`endif

endmodule

// File: rtl/filter_bank.sv
// Multi-channel moving-sum filter bank sharing one delay line.
// Optional peak detection is built when FILTER_BANK_PEAK_EN is defined.
module filter_bank
    import package_settings::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DATA_W       = SIZE_ADC_DATA,
    parameter int unsigned MAX_LOG2_WIN = FB_MAX_LOG2_WIN,
    parameter int unsigned OUT_W        = DATA_W + MAX_LOG2_WIN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    cfg_load,
    input  logic [NUM_CH*3-1:0]     cfg_log2_win,
    input  logic [OUT_W-1:0]        cfg_thr,
    output logic                    out_valid,
    output logic [NUM_CH*OUT_W-1:0] out_data,
    output logic [NUM_CH-1:0]       peak_valid,
    output logic [NUM_CH*OUT_W-1:0] peak_data
);

    localparam int unsigned DEPTH = 2 ** MAX_LOG2_WIN;

    logic [DATA_W-1:0]       line [DEPTH];
    logic [MAX_LOG2_WIN-1:0] wr_ptr;

    // Delay line write; cfg_load empties it and the same-cycle sample lands in slot 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line   <= '{default: '0};
            wr_ptr <= '0;
        end else if (cfg_load) begin
            line <= '{default: '0};
            if (in_valid) begin
                line[0] <= in_data;
                wr_ptr  <= MAX_LOG2_WIN'(1);
            end else begin
                wr_ptr <= '0;
            end
        end else if (in_valid) begin
            line[wr_ptr] <= in_data;
            wr_ptr       <= wr_ptr + MAX_LOG2_WIN'(1);
        end
    end

    // Output strobe follows the sample strobe by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [2:0]              log2_win;
        logic [MAX_LOG2_WIN-1:0] tap;
        logic [OUT_W-1:0]        sum;
        logic                    pv;
        logic [OUT_W-1:0]        pd;

        // Full-depth window truncates to 0 and taps the slot about to be overwritten.
        assign tap = wr_ptr - MAX_LOG2_WIN'(1 << log2_win);

        filter_bank_channel #(
            .DATA_W      (DATA_W),
            .MAX_LOG2_WIN(MAX_LOG2_WIN),
            .OUT_W       (OUT_W)
        ) u_ch (
            .clk         (clk),
            .reset       (reset),
            .clear       (cfg_load),
            .valid       (in_valid),
            .cfg_log2_win(cfg_log2_win[c*3 +: 3]),
            .in_data     (in_data),
            .old_data    (line[tap]),
            .thr         (cfg_thr),
            .log2_win    (log2_win),
            .sum         (sum),
            .peak_valid  (pv),
            .peak_data   (pd)
        );

        assign out_data[c*OUT_W +: OUT_W]  = sum;
        assign peak_valid[c]               = pv;
        assign peak_data[c*OUT_W +: OUT_W] = pd;
    end

endmodule
